// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the round-robin stream arbiter.
// Beat layout: DW bits per beat, end-of-packet flag at LAST_BIT.
package axis_arb_pkg;
  localparam int DW       = 33;
  localparam int LAST_BIT = 32;

  typedef enum logic {ARB_IDLE, ARB_LOCK} arb_state_t;

  // Sized for the largest supported N (16); callers truncate to N bits.
  function automatic logic [15:0] onehot(input logic [3:0] idx);
    return 16'(1) << idx;
  endfunction
endpackage

// File: rtl/axis_arb_rr_pick.sv
// Round-robin picker: first requester at or after ptr, wrapping mod N.
// Purely combinational; double-width rotate followed by a priority encoder.
module axis_arb_rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);
  localparam int PW = $clog2(N);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [PW-1:0]  off;
  logic [PW:0]    sum;

  assign dbl = {req, req};
  assign rot = dbl[ptr +: N];
  assign any = |rot;

  always_comb begin
    off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = PW'(i);
    end
  end

  // Undo the rotation: the winner is ptr + offset, wrapped mod N.
  assign sum = {1'b0, ptr} + {1'b0, off};
  assign idx = (sum >= (PW+1)'(N)) ? PW'(sum - (PW+1)'(N)) : PW'(sum);
endmodule

// File: rtl/axis_rr_arbiter.sv
// N:1 round-robin stream arbiter, zero-latency; the lock holds an offered beat until accepted.
// AXIS_ARB_PKT_LOCK_EN defined: lock held until a last beat; undefined: beat-level arbitration.
module axis_rr_arbiter #(
  parameter int N        = 4,
  parameter int DW       = axis_arb_pkg::DW,
  parameter int LAST_BIT = axis_arb_pkg::LAST_BIT
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [N*DW-1:0] s_data,
  input  logic [N-1:0]    s_valid,
  output logic [N-1:0]    s_ready,
  output logic [DW-1:0]   m0_data,
  output logic            m0_valid,
  input  logic            m0_ready,
  output logic [N-1:0]    grant
);
  import axis_arb_pkg::*;

  localparam int PW = $clog2(N);
`ifdef AXIS_ARB_PKT_LOCK_EN
  localparam bit PKT_LOCK = 1'b1;
`else
  localparam bit PKT_LOCK = 1'b0;
`endif

  arb_state_t    state, state_d;
  logic [PW-1:0] ptr, ptr_d, sel_q, sel_q_d, pick_idx, sel;
  logic          pick_any, owned, xfer, rel;
  logic [N-1:0]  grant_raw;

  function automatic logic [PW-1:0] inc_mod(input logic [PW-1:0] v);
    return (v == PW'(N - 1)) ? '0 : v + 1'b1;
  endfunction

  axis_arb_rr_pick #(.N(N)) u_pick (
    .req (s_valid),
    .ptr (ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign sel       = (state == ARB_LOCK) ? sel_q : pick_idx;
  assign owned     = (state == ARB_LOCK) | pick_any;
  assign grant_raw = owned ? N'(onehot(4'(sel))) : '0;
  assign grant     = reset_n ? grant_raw : '0;
  assign m0_data   = s_data[int'(sel)*DW +: DW];
  assign m0_valid  = s_valid[sel] & (|grant);
  assign s_ready   = grant & {N{m0_ready}};
  assign xfer      = m0_valid & m0_ready;
  // In beat mode every transfer releases; in packet mode only the last beat does.
  assign rel       = xfer & (m0_data[LAST_BIT] | !PKT_LOCK);

  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    sel_q_d = sel_q;
    case (state)
      ARB_IDLE: begin
        if (pick_any) begin
          if (rel) begin
            ptr_d = inc_mod(sel);
          end else begin
            state_d = ARB_LOCK;
            sel_q_d = sel;
          end
        end
      end
      ARB_LOCK: begin
        if (rel) begin
          state_d = ARB_IDLE;
          ptr_d   = inc_mod(sel_q);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ARB_IDLE;
      ptr   <= '0;
      sel_q <= '0;
    end else begin
      state <= state_d;
      ptr   <= ptr_d;
      sel_q <= sel_q_d;
    end
  end
endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Directed self-checking bench for axis_rr_arbiter (N=4, DW=33).
// Expectations follow the build mode selected by AXIS_ARB_PKT_LOCK_EN.
module tb_axis_rr_arbiter;
  localparam int N  = 4;
  localparam int DW = 33;

  localparam logic [DW-1:0] A1  = 33'h0_0000_00A1;
  localparam logic [DW-1:0] A2  = 33'h0_0000_00A2;
  localparam logic [DW-1:0] A3  = 33'h1_0000_00A3;
  localparam logic [DW-1:0] C0  = 33'h1_0000_00C0;
  localparam logic [DW-1:0] B11 = 33'h1_0000_0B11;
  localparam logic [DW-1:0] D1  = 33'h0_0000_00D1;
  localparam logic [DW-1:0] D2  = 33'h1_0000_00D2;
  localparam logic [DW-1:0] E3  = 33'h1_0000_00E3;
  localparam logic [DW-1:0] F1  = 33'h0_0000_00F1;
  localparam logic [DW-1:0] F2  = 33'h1_0000_00F2;
  localparam logic [DW-1:0] G1  = 33'h1_0000_0061;

  typedef struct {
    logic [3:0]    sv;
    logic [DW-1:0] din;
    logic [3:0]    g;
    logic          v;
    logic [DW-1:0] d;
  } row_t;

`ifdef AXIS_ARB_PKT_LOCK_EN
  localparam int T3N = 4;
`else
  localparam int T3N = 6;
`endif

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [N*DW-1:0] s_data;
  logic [N-1:0]    s_valid;
  logic [N-1:0]    s_ready;
  logic [DW-1:0]   m0_data;
  logic            m0_valid;
  logic            m0_ready;
  logic [N-1:0]    grant;

  int n_checks = 0;
  int n_err    = 0;

  row_t t3 [T3N];
  row_t t5 [6];

  axis_rr_arbiter #(.N(N), .DW(DW), .LAST_BIT(32)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .m0_data  (m0_data),
    .m0_valid (m0_valid),
    .m0_ready (m0_ready),
    .grant    (grant)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic [DW-1:0] v);
    s_data[i*DW +: DW] = v;
  endtask

  // Let the combinational path settle, then compare all outputs.
  task automatic expect_out(input string tag, input logic [3:0] g, input logic v, input logic [DW-1:0] d);
    #1;
    check({tag, ".grant"}, 64'(grant), 64'(g));
    check({tag, ".valid"}, 64'(m0_valid), 64'(v));
    check({tag, ".ready"}, 64'(s_ready), 64'(g & {N{m0_ready}}));
    if (v) check({tag, ".data"}, 64'(m0_data), 64'(d));
  endtask

  initial begin
`ifdef AXIS_ARB_PKT_LOCK_EN
    t3 = '{'{4'b0101, A1, 4'b0100, 1'b1, A1},
           '{4'b0101, A2, 4'b0100, 1'b1, A2},
           '{4'b0101, A3, 4'b0100, 1'b1, A3},
           '{4'b0001, A3, 4'b0001, 1'b1, C0}};
    t5 = '{'{4'b1010, D1, 4'b0010, 1'b1, D1},
           '{4'b1000, D2, 4'b0010, 1'b0, D2},
           '{4'b1000, D2, 4'b0010, 1'b0, D2},
           '{4'b1000, D2, 4'b0010, 1'b0, D2},
           '{4'b1010, D2, 4'b0010, 1'b1, D2},
           '{4'b1000, D2, 4'b1000, 1'b1, E3}};
`else
    t3 = '{'{4'b0101, A1, 4'b0100, 1'b1, A1},
           '{4'b0101, A2, 4'b0001, 1'b1, C0},
           '{4'b0101, A2, 4'b0100, 1'b1, A2},
           '{4'b0101, A3, 4'b0001, 1'b1, C0},
           '{4'b0101, A3, 4'b0100, 1'b1, A3},
           '{4'b0001, A3, 4'b0001, 1'b1, C0}};
    t5 = '{'{4'b1010, D1, 4'b0010, 1'b1, D1},
           '{4'b1000, D2, 4'b1000, 1'b1, E3},
           '{4'b1000, D2, 4'b1000, 1'b1, E3},
           '{4'b1000, D2, 4'b1000, 1'b1, E3},
           '{4'b1010, D2, 4'b0010, 1'b1, D2},
           '{4'b1000, D2, 4'b1000, 1'b1, E3}};
`endif

    // Reset and idle: outputs forced low even with valids and ready present.
    s_data   = '0;
    s_valid  = 4'b1111;
    m0_ready = 1'b1;
    expect_out("reset", 4'b0000, 1'b0, '0);
    step();
    step();
    s_valid  = 4'b0000;
    m0_ready = 1'b0;
    reset_n  = 1'b1;
    for (int c = 0; c < 10; c++) begin
      expect_out("idle", 4'b0000, 1'b0, '0);
      step();
    end

    // Round-robin rotation with single-beat packets, starting at ptr=0.
    for (int i = 0; i < N; i++) set_src(i, {1'b1, 32'hB0 + 32'(i)});
    s_valid  = 4'b1111;
    m0_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      expect_out("rr", 4'(1 << (k % 4)), 1'b1, {1'b1, 32'hB0 + 32'(k % 4)});
      step();
    end
    s_valid  = 4'b0000;
    m0_ready = 1'b0;
    step();

    // Backpressure: src1 offered, src0 arrives later and must not steal (ptr=2).
    set_src(0, C0);
    set_src(1, B11);
    s_valid = 4'b0010;
    for (int c = 0; c < 5; c++) begin
      if (c == 2) s_valid = 4'b0011;
      expect_out("bp_hold", 4'b0010, 1'b1, B11);
      step();
    end
    m0_ready = 1'b1;
    expect_out("bp_xfer", 4'b0010, 1'b1, B11);
    step();
    s_valid = 4'b0001;
    expect_out("bp_next", 4'b0001, 1'b1, C0);
    s_valid = 4'b0000;
    step();

    // Packet atomicity (packet mode) / interleave (beat mode), ptr=2.
    for (int r = 0; r < T3N; r++) begin
      s_valid = t3[r].sv;
      set_src(2, t3[r].din);
      expect_out("pkt", t3[r].g, t3[r].v, t3[r].d);
      step();
    end
    s_valid = 4'b0000;

    // Owner bubble mid-packet with src3 waiting, ptr=1.
    set_src(3, E3);
    for (int r = 0; r < 6; r++) begin
      s_valid = t5[r].sv;
      set_src(1, t5[r].din);
      expect_out("bubble", t5[r].g, t5[r].v, t5[r].d);
      step();
    end
    s_valid = 4'b0000;

    // Reset mid-packet: move ptr to 2, lock onto src3, then reset.
    set_src(1, G1);
    s_valid = 4'b0010;
    expect_out("pre_rst_src1", 4'b0010, 1'b1, G1);
    step();
    set_src(3, F1);
    s_valid = 4'b1000;
    expect_out("src3_beat1", 4'b1000, 1'b1, F1);
    step();
    set_src(3, F2);
    m0_ready = 1'b0;
    expect_out("src3_beat2", 4'b1000, 1'b1, F2);
    step();
    s_valid = 4'b1111;
    expect_out("src3_locked", 4'b1000, 1'b1, F2);
    m0_ready = 1'b1;
    reset_n  = 1'b0;
    expect_out("rst_mid", 4'b0000, 1'b0, '0);
    step();
    reset_n = 1'b1;
    expect_out("post_rst0", 4'b0001, 1'b1, C0);
    step();
    expect_out("post_rst1", 4'b0010, 1'b1, G1);
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
